seq_divider: RTL

Parametrised multi-cycle restoring divider with its own control FSM and a start/done handshake. It generalises the fixed 32-bit compare/subtract datapath: operand width is a parameter, the sequencing is internal, and it adds a divide-by-zero path and optional signed operation. It sits beside the arithmetic datapath as a self-contained divide unit behind a simple request/response handshake.

---
 rtl/seq_divider_if.sv | 23 ++
 rtl/seq_divider.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/seq_divider_if.sv
// Request/response bundle for seq_divider: operands and start in, results and status out.
interface seq_divider_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, one quotient bit per cycle, start/done handshake.
// Define SEQ_DIV_SIGNED_EN for two's-complement operands (adds a FIX cycle).
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  seq_divider_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
`ifdef SEQ_DIV_SIGNED_EN
  localparam logic [1:0] S_FIX  = 2'd2;
`endif
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rmd_q, rmd_d;
  logic             dbz_q, dbz_d;
`ifdef SEQ_DIV_SIGNED_EN
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
`endif

  // The extra top bit of rem_q is always zero after a restoring step, so the
  // borrow bit of this difference is exactly "shifted remainder < divisor".
  logic [WIDTH+1:0] rem_sh;
  logic [WIDTH+1:0] diff;
  logic             ge;

  always_comb begin
    rem_sh = {rem_q, q_q[WIDTH-1]};
    diff   = rem_sh - {2'b00, dvs_q};
    ge     = ~diff[WIDTH+1];
  end

  // NOTE: every next-state variable gets its hold value first, so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    q_d     = q_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    dbz_d   = dbz_q;
`ifdef SEQ_DIV_SIGNED_EN
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          rem_d = '0;
          cnt_d = CW'(WIDTH - 1);
`ifdef SEQ_DIV_SIGNED_EN
          q_d    = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
          dvs_d  = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;
          qneg_d = bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
          rneg_d = bus.dividend[WIDTH-1];
`else
          q_d    = bus.dividend;
          dvs_d  = bus.divisor;
`endif
          if (bus.divisor == '0) begin
            quo_d   = '1;
            rmd_d   = bus.dividend;
            dbz_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
          end
        end
      end

      S_RUN: begin
        rem_d = ge ? diff[WIDTH:0] : rem_sh[WIDTH:0];
        q_d   = {q_q[WIDTH-2:0], ge};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
`ifdef SEQ_DIV_SIGNED_EN
          state_d = S_FIX;
`else
          quo_d   = q_d;
          rmd_d   = rem_d[WIDTH-1:0];
          dbz_d   = 1'b0;
          state_d = S_DONE;
`endif
        end
      end

`ifdef SEQ_DIV_SIGNED_EN
      // Magnitudes were divided; restore signs so the quotient truncates toward zero.
      S_FIX: begin
        quo_d   = qneg_q ? -q_q : q_q;
        rmd_d   = rneg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
        dbz_d   = 1'b0;
        state_d = S_DONE;
      end
`endif

      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      q_q     <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      rmd_q   <= '0;
      dbz_q   <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      q_q     <= q_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      dbz_q   <= dbz_d;
`ifdef SEQ_DIV_SIGNED_EN
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
`endif
    end
  end

  assign bus.busy        = (state_q != S_IDLE);
  assign bus.done        = (state_q == S_DONE);
  assign bus.quotient    = quo_q;
  assign bus.remainder   = rmd_q;
  assign bus.div_by_zero = dbz_q;

endmodule
